// File: rtl/conv_scale_pipe_if.sv
// ---------------------------------------------------------------------------
// conv_scale_pipe_if
// Stream bundle for the requantisation stage: accumulator beats in, activation
// beats out, each side using a valid/ready handshake.
//   S_Data/S_Valid/S_Ready : accumulator lanes from the convolution core
//   M_Data/M_Valid/M_Ready : saturated activation lanes to the consumer
// Modports:
//   slave  - the requantisation block (consumes S_*, produces M_*)
//   master - the surrounding environment (produces S_*, consumes M_*)
// ---------------------------------------------------------------------------
interface conv_scale_pipe_if #(
  parameter int PICTURE_NUM     = 1,
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA_ADD  = 32,
  parameter int WIDTH_OUT       = 8
);
  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;

  logic [LANES*WIDTH_DATA_ADD-1:0] S_Data;
  logic                            S_Valid;
  logic                            S_Ready;
  logic [LANES*WIDTH_OUT-1:0]      M_Data;
  logic                            M_Valid;
  logic                            M_Ready;

  modport slave  (input  S_Data, S_Valid, M_Ready,
                  output S_Ready, M_Data, M_Valid);
  modport master (output S_Data, S_Valid, M_Ready,
                  input  S_Ready, M_Data, M_Valid);
endinterface

// File: rtl/conv_scale_pipe.sv
// ---------------------------------------------------------------------------
// conv_scale_pipe
// Per-channel requantisation after the convolution accumulator. Each lane is
// multiplied by its channel scale, shifted right with round-half-up, optionally
// ReLU-clamped and saturated to WIDTH_OUT. Three register stages, all of which
// advance together whenever the output register is free or being drained.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : S_Data/S_Valid/S_Ready in, M_Data/M_Valid/M_Ready out
//   Scale_Data_In   : per-channel signed scales
//   Shift_In        : common right-shift amount
//   Relu_En_In      : clamp negative results to zero
//   Scale_Load      : capture the three config inputs on this edge
// Lane k = j*PICTURE_NUM + i carries picture i of channel j.
// ---------------------------------------------------------------------------
module conv_scale_pipe #(
  parameter int PICTURE_NUM     = 1,
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA_ADD  = 32,
  parameter int WIDTH_SCALE     = 32,
  parameter int WIDTH_SHIFT     = 6,
  parameter int WIDTH_OUT       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  conv_scale_pipe_if.slave                   bus,
  input  logic [CHANNEL_OUT_NUM*WIDTH_SCALE-1:0] Scale_Data_In,
  input  logic [WIDTH_SHIFT-1:0]             Shift_In,
  input  logic                               Relu_En_In,
  input  logic                               Scale_Load
);
  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;
  localparam int WP    = WIDTH_DATA_ADD + WIDTH_SCALE;  // full product width
  localparam int WR    = WP + 1;                        // one guard bit for the rounding add

  // ReLU then saturate: in range when all bits above the output sign bit agree
  function automatic logic [WIDTH_OUT-1:0] relu_sat(input logic signed [WR-1:0] r,
                                                     input logic relu);
    logic [WIDTH_OUT-1:0] res;
    if (relu && r[WR-1]) begin
      res = {WIDTH_OUT{1'b0}};
    end else if ((&r[WR-1:WIDTH_OUT-1]) || !(|r[WR-1:WIDTH_OUT-1])) begin
      res = r[WIDTH_OUT-1:0];
    end else begin
      res = {r[WR-1], {(WIDTH_OUT-1){~r[WR-1]}}};
    end
    return res;
  endfunction

  logic [CHANNEL_OUT_NUM*WIDTH_SCALE-1:0] r_scale;
  logic [WIDTH_SHIFT-1:0]                 r_shift;
  logic                                   r_relu;

  logic                    w_adv;
  logic signed [WP-1:0]    w_prod [LANES];
  logic signed [WR-1:0]    w_rnd  [LANES];
  logic [LANES*WIDTH_OUT-1:0] w_out;

  logic                    r_v1;
  logic signed [WP-1:0]    r_p1 [LANES];
  logic [WIDTH_SHIFT-1:0]  r_sh1;
  logic                    r_relu1;

  logic                    r_v2;
  logic signed [WR-1:0]    r_r2 [LANES];
  logic                    r_relu2;

  logic                    r_m_valid;
  logic [LANES*WIDTH_OUT-1:0] r_m_data;

  // Whole pipe moves as one; bubbles are carried, not squeezed out
  assign w_adv       = !r_m_valid || bus.M_Ready;
  assign bus.S_Ready = w_adv;
  assign bus.M_Valid = r_m_valid;
  assign bus.M_Data  = r_m_data;

  // Config registers; a beat accepted on the load edge still sees the old values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scale <= {(CHANNEL_OUT_NUM*WIDTH_SCALE){1'b0}};
      r_shift <= {WIDTH_SHIFT{1'b0}};
      r_relu  <= 1'b0;
    end else if (Scale_Load) begin
      r_scale <= Scale_Data_In;
      r_shift <= Shift_In;
      r_relu  <= Relu_En_In;
    end
  end

  // Stage-1 products: signed lane times signed channel scale, full width
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_prod[k] = WP'($signed(bus.S_Data[k*WIDTH_DATA_ADD +: WIDTH_DATA_ADD]))
                * WP'($signed(r_scale[(k/PICTURE_NUM)*WIDTH_SCALE +: WIDTH_SCALE]));
    end
  end

  // Stage-2 rounding: add half an LSB of the shifted result, then arithmetic shift
  always_comb begin
    logic signed [WR-1:0] v_half;
    logic signed [WR-1:0] v_sum;
    v_half = {WR{1'b0}};
    v_sum  = {WR{1'b0}};
    if (r_sh1 == {WIDTH_SHIFT{1'b0}}) begin
      v_half = {WR{1'b0}};
    end else begin
      v_half = {{(WR-1){1'b0}}, 1'b1} << (r_sh1 - WIDTH_SHIFT'(1));
    end
    for (int k = 0; k < LANES; k++) begin
      v_sum    = WR'(r_p1[k]) + v_half;
      w_rnd[k] = v_sum >>> r_sh1;
    end
  end

  // Stage-3 clamp and saturate every lane
  always_comb begin
    w_out = {(LANES*WIDTH_OUT){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      w_out[k*WIDTH_OUT +: WIDTH_OUT] = relu_sat(r_r2[k], r_relu2);
    end
  end

  // Pipeline registers; each beat carries the shift/relu it was accepted with
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_m_valid <= 1'b0;
      r_sh1     <= {WIDTH_SHIFT{1'b0}};
      r_relu1   <= 1'b0;
      r_relu2   <= 1'b0;
      r_m_data  <= {(LANES*WIDTH_OUT){1'b0}};
      for (int k = 0; k < LANES; k++) begin
        r_p1[k] <= {WP{1'b0}};
        r_r2[k] <= {WR{1'b0}};
      end
    end else if (w_adv) begin
      r_v1      <= bus.S_Valid;
      r_sh1     <= r_shift;
      r_relu1   <= r_relu;
      r_p1      <= w_prod;
      r_v2      <= r_v1;
      r_relu2   <= r_relu1;
      r_r2      <= w_rnd;
      r_m_valid <= r_v2;
      if (r_v2) begin
        r_m_data <= w_out;
      end
    end
  end
endmodule

// File: tb/tb_conv_scale_pipe.sv
// Self-checking bench for conv_scale_pipe (two pictures, eight channels).
module tb_conv_scale_pipe;
  localparam int PN = 2, CN = 8, LANES = PN * CN;
  localparam int WD = 32, WS = 32, WSH = 6, WO = 8;
  localparam int DW = LANES * WD, OW = LANES * WO, SW = CN * WS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [SW-1:0]  Scale_Data_In = '0;
  logic [WSH-1:0] Shift_In      = '0;
  logic           Relu_En_In    = 1'b0;
  logic           Scale_Load    = 1'b0;

  conv_scale_pipe_if #(.PICTURE_NUM(PN), .CHANNEL_OUT_NUM(CN),
                       .WIDTH_DATA_ADD(WD), .WIDTH_OUT(WO)) bus ();

  conv_scale_pipe #(.PICTURE_NUM(PN), .CHANNEL_OUT_NUM(CN), .WIDTH_DATA_ADD(WD),
                    .WIDTH_SCALE(WS), .WIDTH_SHIFT(WSH), .WIDTH_OUT(WO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .Scale_Data_In(Scale_Data_In), .Shift_In(Shift_In),
    .Relu_En_In(Relu_En_In), .Scale_Load(Scale_Load));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: the config as the block should currently hold it
  int m_scale [CN];
  int m_shift;
  bit m_relu;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];

  // requantise one value with plain arithmetic: floor((d*s + half) / 2^sh)
  function automatic logic [7:0] ref_lane(input logic signed [31:0] d, input int s,
                                          input int sh, input bit relu);
    logic signed [127:0] num, den, q, s128;
    s128 = 128'(s);
    num  = 128'(d) * s128;
    if (sh > 0) num = num + (128'sd1 <<< (sh - 1));
    den = 128'sd1 <<< sh;
    q   = num / den;
    if ((num % den) != 128'sd0 && num < 128'sd0) q = q - 128'sd1;
    if (relu && q < 128'sd0) q = 128'sd0;
    if (q > 128'sd127) q = 128'sd127;
    if (q < -128'sd128) q = -128'sd128;
    return q[7:0];
  endfunction

  function automatic logic [OW-1:0] model_beat(input logic [DW-1:0] v);
    logic [OW-1:0] r;
    logic signed [31:0] d;
    for (int k = 0; k < LANES; k++) begin
      d = $signed(v[k*WD +: WD]);
      r[k*WO +: WO] = ref_lane(d, m_scale[k/PN], m_shift, m_relu);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input int v);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WD +: WD] = v;
    return r;
  endfunction

  function automatic logic [OW-1:0] fill8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {LANES{b}};
  endfunction

  function automatic logic [SW-1:0] scale_all(input int s);
    logic [SW-1:0] r;
    for (int j = 0; j < CN; j++) r[j*WS +: WS] = s;
    return r;
  endfunction

  // observe accepts, emits and config loads at the falling edge
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      got_q.delete();
      for (int j = 0; j < CN; j++) m_scale[j] <= 0;
      m_shift <= 0;
      m_relu  <= 1'b0;
    end else begin
      if (bus.S_Valid && bus.S_Ready) exp_q.push_back(model_beat(bus.S_Data));
      if (bus.M_Valid && bus.M_Ready) got_q.push_back(bus.M_Data);
      if (Scale_Load) begin
        for (int j = 0; j < CN; j++) m_scale[j] <= $signed(Scale_Data_In[j*WS +: WS]);
        m_shift <= int'(Shift_In);
        m_relu  <= Relu_En_In;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call just after a rising edge
  task automatic load_cfg(input logic [SW-1:0] sc, input int sh, input bit rl);
    Scale_Data_In = sc;
    Shift_In      = WSH'(sh);
    Relu_En_In    = rl;
    Scale_Load    = 1'b1;
    tick();
    Scale_Load    = 1'b0;
  endtask

  // call just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [DW-1:0] v);
    int n;
    n = 0;
    bus.S_Data  = v;
    bus.S_Valid = 1'b1;
    @(negedge clk);
    while (!bus.S_Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.S_Valid = 1'b0;
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: S_Ready stayed 0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    int c;
    c = 0;
    while (got_q.size() < n && c < 300) begin
      tick();
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [OW-1:0] g, e;
    bit ok, seen;
    int lat;
    rst = 1'b0;
    bus.M_Ready = 1'b1;
    bus.S_Data  = fill(5);
    bus.S_Valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.M_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.M_Valid); end
    total++;
    if (bus.M_Data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.M_Data); end
    @(posedge clk); #1;
    bus.S_Valid = 1'b0;
    rst = 1'b1;
    tick();
    load_cfg(scale_all(256), 8, 1'b0);
    bus.S_Data  = fill(1000);
    bus.S_Valid = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.S_Valid = 1'b0;
      @(negedge clk);
      if (!seen && bus.M_Valid) begin seen = 1'b1; lat = c; end
    end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL reset_latency: got %0d edges want 3", lat); end
    tick();
    wait_out(1, ok);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++; $display("FAIL reset_first_beat: got %0d beats want 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (g !== fill8(127)) begin bad++; $display("FAIL reset_sat: got %h want %h", g, fill8(127)); end
      total++;
      if (g !== e) begin bad++; $display("FAIL reset_model: got %h want %h", g, e); end
    end
  endtask

  task automatic test_rounding();
    int d [6] = '{3, -3, 5, -5, 100, -100};
    int w [6] = '{2, -1, 3, -2, 100, -100};
    logic [OW-1:0] g, e;
    bit ok;
    load_cfg(scale_all(1), 1, 1'b0);
    for (int i = 0; i < 4; i++) send(fill(d[i]));
    load_cfg(scale_all(256), 8, 1'b0);
    for (int i = 4; i < 6; i++) send(fill(d[i]));
    wait_out(6, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rounding_count: got %0d beats want 6", got_q.size()); end
    for (int i = 0; i < 6 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (g !== fill8(w[i])) begin bad++; $display("FAIL rounding_%0d: got %h want %h", i, g, fill8(w[i])); end
      total++;
      if (g !== e) begin bad++; $display("FAIL rounding_model_%0d: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_sat_relu();
    int w [4] = '{127, -128, 127, 0};
    logic [OW-1:0] g, e;
    bit ok;
    load_cfg(scale_all(1), 0, 1'b0);
    send(fill(1000));
    send(fill(-1000));
    load_cfg(scale_all(1), 0, 1'b1);
    send(fill(1000));
    send(fill(-1000));
    wait_out(4, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL sat_count: got %0d beats want 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (g !== fill8(w[i])) begin bad++; $display("FAIL sat_relu_%0d: got %h want %h", i, g, fill8(w[i])); end
      total++;
      if (g !== e) begin bad++; $display("FAIL sat_model_%0d: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_per_channel();
    logic [SW-1:0] sc;
    logic [OW-1:0] g, e, want;
    int d [2] = '{10, 20};
    int v;
    bit ok;
    for (int j = 0; j < CN; j++) sc[j*WS +: WS] = j + 1;
    load_cfg(sc, 0, 1'b0);
    send(fill(d[0]));
    send(fill(d[1]));
    wait_out(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL chan_count: got %0d beats want 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      for (int k = 0; k < LANES; k++) begin
        v = d[i] * (k / PN + 1);
        if (v > 127) v = 127;
        want[k*WO +: WO] = v[7:0];
      end
      total++;
      if (g !== want) begin bad++; $display("FAIL per_channel_%0d: got %h want %h", i, g, want); end
      total++;
      if (g !== e) begin bad++; $display("FAIL chan_model_%0d: got %h want %h", i, g, e); end
      for (int j = 0; j < CN; j++) begin
        total++;
        if (g[(j*PN)*WO +: WO] !== g[(j*PN+1)*WO +: WO]) begin
          bad++; $display("FAIL picture_pair_ch%0d: got %h want %h", j, g[(j*PN+1)*WO +: WO], g[(j*PN)*WO +: WO]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] g, held;
    bit ok;
    load_cfg(scale_all(1), 0, 1'b0);
    fork
      begin
        for (int i = 0; i < 20; i++) send(fill(i));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.M_Ready = 1'b0;
        held = bus.M_Data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          total++;
          if (bus.S_Ready !== 1'b0) begin bad++; $display("FAIL stall_ready_%0d: got %b want 0", c, bus.S_Ready); end
          total++;
          if (bus.M_Valid !== 1'b1) begin bad++; $display("FAIL stall_valid_%0d: got %b want 1", c, bus.M_Valid); end
          total++;
          if (bus.M_Data !== held) begin bad++; $display("FAIL stall_data_%0d: got %h want %h", c, bus.M_Data, held); end
        end
        @(posedge clk); #1;
        bus.M_Ready = 1'b1;
      end
    join
    wait_out(20, ok);
    repeat (5) tick();
    total++;
    if (got_q.size() != 20) begin bad++; $display("FAIL bp_count: got %0d beats want 20", got_q.size()); end
    for (int i = 0; i < 20 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      total++;
      if (g !== fill8(i)) begin bad++; $display("FAIL bp_order_%0d: got %h want %h", i, g, fill8(i)); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_config_timing();
    logic [OW-1:0] g;
    bit ok, seen;
    int w [2] = '{10, 20};
    load_cfg(scale_all(1), 0, 1'b0);
    Scale_Data_In = scale_all(2);
    Scale_Load    = 1'b1;
    send(fill(10));
    Scale_Load    = 1'b0;
    send(fill(10));
    wait_out(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cfg_count: got %0d beats want 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      total++;
      if (g !== fill8(w[i])) begin bad++; $display("FAIL cfg_timing_%0d: got %h want %h", i, g, fill8(w[i])); end
    end
    exp_q.delete();
    // two beats in flight, then reset
    send(fill(7));
    send(fill(8));
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.M_Valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_valid: got M_Valid=1 want 0"); end
    tick();
    send(fill(1000));
    wait_out(1, ok);
    total++;
    if (!ok || got_q.size() != 1) begin
      bad++; $display("FAIL flush_count: got %0d beats want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      total++;
      if (g !== fill8(0)) begin bad++; $display("FAIL flush_cfg_cleared: got %h want %h", g, fill8(0)); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    logic [SW-1:0] sc;
    logic [OW-1:0] g, e;
    bit ok, done;
    int n;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            for (int j = 0; j < CN; j++) sc[j*WS +: WS] = int'($urandom_range(0, 600)) - 300;
            Scale_Data_In = sc;
            Shift_In      = WSH'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 10));
            Relu_En_In    = 1'($urandom_range(0, 1));
            Scale_Load    = 1'b1;
          end
          for (int k = 0; k < LANES; k++)
            v[k*WD +: WD] = ($urandom_range(0, 7) == 0) ? $urandom : int'($urandom_range(0, 4000)) - 2000;
          send(v);
          Scale_Load = 1'b0;
          if ($urandom_range(0, 3) == 0) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.M_Ready = ($urandom_range(0, 3) != 0);
        end
        bus.M_Ready = 1'b1;
      end
    join
    n = exp_q.size();
    wait_out(n, ok);
    repeat (4) tick();
    total++;
    if (!ok || got_q.size() != n) begin bad++; $display("FAIL rand_count: got %0d beats want %0d", got_q.size(), n); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rand_beat: got %h want %h", g, e); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.S_Data  = '0;
    bus.S_Valid = 1'b0;
    bus.M_Ready = 1'b1;
    test_reset();
    test_rounding();
    test_sat_relu();
    test_per_channel();
    test_backpressure();
    test_config_timing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_scale_pipe.md
Name: conv_scale_pipe

Overview:
Per-channel requantisation stage placed after the convolution accumulator. Each lane's signed accumulator is multiplied by that lane's channel scale, then arithmetically right-shifted with round-half-up. An optional ReLU clamp follows, and the result is saturated to the activation width. Compared with a bare multiplier, this block adds a valid/ready stream interface with backpressure, runtime-loadable scale and shift, rounding, ReLU and saturation.

Parameters:
PICTURE_NUM, 1, number of pictures processed in parallel
CHANNEL_OUT_NUM, 8, number of output channels per beat
WIDTH_DATA_ADD, 32, signed accumulator width per lane
WIDTH_SCALE, 32, signed scale width per channel
WIDTH_SHIFT, 6, right-shift amount width (0..2^WIDTH_SHIFT-1)
WIDTH_OUT, 8, signed output width per lane

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
S_Data  in  PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_DATA_ADD  input lanes; lane k=j*PICTURE_NUM+i holds picture i, channel j, at bits [(k+1)*WIDTH_DATA_ADD-1 : k*WIDTH_DATA_ADD]
S_Valid  in  1  input beat valid
S_Ready  out  1  block can accept a beat
Scale_Data_In  in  CHANNEL_OUT_NUM*WIDTH_SCALE  scale for channel j at bits [(j+1)*WIDTH_SCALE-1 : j*WIDTH_SCALE]
Shift_In  in  WIDTH_SHIFT  common right-shift amount
Relu_En_In  in  1  clamp negative results to 0
Scale_Load  in  1  capture Scale_Data_In, Shift_In and Relu_En_In on this edge
M_Data  out  PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_OUT  output lanes, same lane ordering as S_Data
M_Valid  out  1  output beat valid
M_Ready  in  1  downstream accepts the beat

Behaviour:
- Reset (rst=0, asynchronous): all pipeline valid bits clear, M_Valid=0, M_Data=0.
- Reset also clears config registers: scale=0, shift=0, relu=0.
- S_Ready is 1 during reset deassertion only if M_Ready allows it (see the advance rule below).
- Config: on a clk edge with Scale_Load=1, the config registers load. A beat accepted on the same edge uses the OLD config; beats accepted on later edges use the new config.
- Config is sampled per beat at stage 1. Each in-flight beat keeps the config it was accepted with.
- Pipeline has 3 stages; latency from accept to M_Valid is 3 cycles when never stalled.
- Advance rule: adv = !M_Valid || M_Ready. All stages shift only when adv=1. S_Ready = adv (combinational).
- Accept occurs when S_Valid && S_Ready.
- Bubbles are not compressed: on adv=1, each valid bit shifts unconditionally.
- Stage 1: register the product P = signed(S_Data lane) * signed(scale[j]), full width WIDTH_DATA_ADD+WIDTH_SCALE. Capture the beat's shift and relu alongside.
- Stage 2: R = (P + (shift==0 ? 0 : 1<<(shift-1))) >>> shift. The addition uses one guard bit, so it cannot overflow. This gives round-half-toward-+inf.
- Stage 3: if relu and R<0, R=0. Then saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1] and register into M_Data.
- While M_Valid=1 and M_Ready=0: M_Data and M_Valid hold stable, S_Ready=0, no beat is lost or duplicated.
- Simultaneous M_Ready=1 and S_Valid=1 with a full pipeline: accept and emit on the same edge; sustained throughput is 1 beat/cycle.
- Reset asserted mid-stream flushes all in-flight beats; no output is produced for them after reset releases.
- Lanes are independent; all lanes of a beat share one valid bit.

Test Plan:
- Reset: hold rst=0 with S_Valid=1 -> M_Valid=0, M_Data=0. Release rst, load scale=256, shift=8, relu=0, send data=1000 on all lanes -> M_Data lanes=127 (saturated), M_Valid rises exactly 3 cycles after accept.
- Rounding: scale=1, shift=1; data 3, -3, 5, -5 -> 2, -1, 3, -2. Then scale=256, shift=8, data=100 -> 100; data=-100 -> -100.
- Saturation/ReLU: scale=1, shift=0; data 1000 -> 127, -1000 -> -128. Same data with relu=1 -> 127, 0.
- Per-channel: CHANNEL_OUT_NUM=8, scale[j]=j+1, shift=0, data=10 on all lanes -> channel j outputs 10*(j+1), saturated at 127 where needed. With PICTURE_NUM=2, lanes for both pictures of channel j match.
- Backpressure: stream 20 beats (data=index) at full rate, drop M_Ready for 5 cycles mid-stream -> S_Ready=0 during the stall, M_Data stable, all 20 outputs appear in order with no loss or duplication.
- Config timing: Scale_Load with scale=2 on the same edge as accepting a beat (data=10, old scale=1, shift=0) -> output 10; next beat data=10 -> 20. Separately, assert rst with 2 beats in flight -> no M_Valid after release until new beats are accepted.
